// File: rtl/line_shift_taps_multi.sv
// rtl/line_shift_taps_multi.sv - multi-tap run-time-length line shift buffer for sliding-window kernels
module line_shift_taps_multi #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LINE   = 640,
   parameter int NUM_TAPS   = 2,
   parameter int LEN_W      = 11
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_clken,
   input  logic                           i_sync_clr,
   input  logic [LEN_W-1:0]               i_line_len,
   input  logic [DATA_WIDTH-1:0]          i_shiftin,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] o_taps,
   output logic [NUM_TAPS-1:0]            o_taps_valid,
   output logic                           o_out_valid,
   output logic [LEN_W-1:0]               o_col_idx
);

   // fill counts up to NUM_TAPS*L, and L < 2^LEN_W, so this width always holds it
   localparam int FILL_W = LEN_W + $clog2(NUM_TAPS + 1);
   localparam int IDX_W  = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);

   logic [DATA_WIDTH-1:0] r_mem [NUM_TAPS][MAX_LINE];

   logic [LEN_W-1:0]               r_ptr;
   logic [LEN_W-1:0]               r_len;
   logic [FILL_W-1:0]              r_fill;
   logic [NUM_TAPS*DATA_WIDTH-1:0] r_taps;
   logic [NUM_TAPS-1:0]            r_valid;
   logic                           r_out_valid;
   logic [LEN_W-1:0]               r_col;

   logic [LEN_W-1:0]               w_len_new;
   logic [LEN_W-1:0]               w_len_eff;
   logic [LEN_W-1:0]               w_ptr_eff;
   logic [FILL_W-1:0]              w_fill_eff;
   logic [FILL_W-1:0]              w_fill_max;
   logic [FILL_W-1:0]              w_fill_next;
   logic [LEN_W-1:0]               w_ptr_next;
   logic [IDX_W-1:0]               w_idx;
   logic [DATA_WIDTH-1:0]          w_rd [NUM_TAPS];
   logic [NUM_TAPS-1:0]            w_valid_next;
   logic [NUM_TAPS*DATA_WIDTH-1:0] w_taps_next;

   // sync_clr takes effect before a same-cycle sample, so the sample sees ptr=0, fill=0 and the new length
   always_comb begin
      w_len_new   = ((i_line_len == '0) || (i_line_len > MAX_LEN)) ? MAX_LEN : i_line_len;
      w_len_eff   = i_sync_clr ? w_len_new : r_len;
      w_ptr_eff   = i_sync_clr ? '0 : r_ptr;
      w_fill_eff  = i_sync_clr ? '0 : r_fill;
      w_fill_max  = FILL_W'(NUM_TAPS) * FILL_W'(w_len_eff);
      w_fill_next = (w_fill_eff >= w_fill_max) ? w_fill_max : w_fill_eff + FILL_W'(1);
      w_ptr_next  = (w_ptr_eff == w_len_eff - LEN_W'(1)) ? '0 : w_ptr_eff + LEN_W'(1);
      w_idx       = IDX_W'(w_ptr_eff);
   end

   // pre-write read of every tap memory at the shared pointer; taps gated to zero until one full delay has filled
   always_comb begin
      w_valid_next = '0;
      w_taps_next  = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         w_rd[k]         = r_mem[k][w_idx];
         w_valid_next[k] = (w_fill_eff >= FILL_W'(k + 1) * FILL_W'(w_len_eff));
         w_taps_next[k*DATA_WIDTH +: DATA_WIDTH] = w_valid_next[k] ? w_rd[k] : '0;
      end
   end

   // tap memories cascade: each line's oldest word moves into the next tap's memory
   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_mem
      if (g == 0) begin : g_first
         always_ff @(posedge i_clock) begin
            if (i_clken) r_mem[0][w_idx] <= i_shiftin;
         end
      end else begin : g_rest
         always_ff @(posedge i_clock) begin
            if (i_clken) r_mem[g][w_idx] <= w_rd[g-1];
         end
      end
   end

   // pointer, fill, length and registered outputs; clear-only cycles zero the taps without advancing
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ptr       <= '0;
         r_len       <= MAX_LEN;
         r_fill      <= '0;
         r_taps      <= '0;
         r_valid     <= '0;
         r_out_valid <= 1'b0;
         r_col       <= '0;
      end else begin
         r_out_valid <= i_clken;
         if (i_clken) begin
            r_ptr   <= w_ptr_next;
            r_len   <= w_len_eff;
            r_fill  <= w_fill_next;
            r_taps  <= w_taps_next;
            r_valid <= w_valid_next;
            r_col   <= w_ptr_eff;
         end else if (i_sync_clr) begin
            r_ptr   <= '0;
            r_len   <= w_len_new;
            r_fill  <= '0;
            r_taps  <= '0;
            r_valid <= '0;
         end
      end
   end

   assign o_taps       = r_taps;
   assign o_taps_valid = r_valid;
   assign o_out_valid  = r_out_valid;
   assign o_col_idx    = r_col;

endmodule

// File: tb/tb_line_shift_taps_multi.sv
// tb/tb_line_shift_taps_multi.sv - scoreboard bench for line_shift_taps_multi
module tb_line_shift_taps_multi;
   localparam int DW = 8;
   localparam int ML = 8;
   localparam int LW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_ce, a_clr;
   logic [LW-1:0] a_len;
   logic [DW-1:0] a_d;
   logic [15:0]   a_taps;
   logic [1:0]    a_tv;
   logic          a_ov;
   logic [LW-1:0] a_col;

   logic          b_ce, b_clr;
   logic [LW-1:0] b_len;
   logic [DW-1:0] b_d;
   logic [31:0]   b_taps;
   logic [3:0]    b_tv;
   logic          b_ov;
   logic [LW-1:0] b_col;

   line_shift_taps_multi #(.DATA_WIDTH(DW), .MAX_LINE(ML), .NUM_TAPS(2), .LEN_W(LW)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_clken(a_ce), .i_sync_clr(a_clr), .i_line_len(a_len),
      .i_shiftin(a_d), .o_taps(a_taps), .o_taps_valid(a_tv), .o_out_valid(a_ov), .o_col_idx(a_col));

   line_shift_taps_multi #(.DATA_WIDTH(DW), .MAX_LINE(ML), .NUM_TAPS(4), .LEN_W(LW)) u_dut4 (
      .i_clock(clk), .i_reset(rst), .i_clken(b_ce), .i_sync_clr(b_clr), .i_line_len(b_len),
      .i_shiftin(b_d), .o_taps(b_taps), .o_taps_valid(b_tv), .o_out_valid(b_ov), .o_col_idx(b_col));

   typedef struct packed {
      logic [15:0]   taps;
      logic [1:0]    tv;
      logic [LW-1:0] col;
   } exp_t;

   exp_t sb[$];
   int   hist[$];
   int   m_len;
   exp_t m_hold;
   int   errors = 0;
   int   checks = 0;

   // drive one cycle on the 2-tap DUT, advance the reference model and queue the expected output
   task automatic step(input logic ce, input logic clr, input logic [LW-1:0] len, input logic [DW-1:0] d);
      exp_t e;
      int   n;
      @(negedge clk);
      a_ce = ce; a_clr = clr; a_len = len; a_d = d;
      if (clr) begin
         hist.delete();
         m_len = (len == 0 || len > ML) ? ML : int'(len);
         if (!ce) begin
            m_hold.taps = '0;
            m_hold.tv   = '0;
         end
      end
      if (ce) begin
         n = hist.size();
         e = '0;
         for (int k = 0; k < 2; k++) begin
            if (n >= (k + 1) * m_len) begin
               e.tv[k] = 1'b1;
               e.taps[k*8 +: 8] = 8'(hist[n - (k + 1) * m_len]);
            end
         end
         e.col = LW'(n % m_len);
         hist.push_back(int'(d));
         sb.push_back(e);
         m_hold = e;
      end
      @(posedge clk);
      #1;
      a_ce = 1'b0; a_clr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_ce = 0; a_clr = 0; a_len = 0; a_d = 0;
      b_ce = 0; b_clr = 0; b_len = 0; b_d = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_taps, a_tv, a_ov, a_col} !== '0) begin
         errors++;
         $display("FAIL reset_state got taps=%h tv=%b ov=%b col=%0d exp all zero", a_taps, a_tv, a_ov, a_col);
      end
      @(negedge clk);
      rst = 1'b0;
      m_len = ML; m_hold = '0;
   endtask

   task automatic test_basic;
      exp_t e;
      logic [7:0] v;
      step(1'b0, 1'b1, 4'd4, 8'd0);
      checks++;
      if (a_ov !== 1'b0 || a_taps !== 16'h0 || a_tv !== 2'b00) begin
         errors++;
         $display("FAIL basic_clr got ov=%b taps=%h tv=%b exp ov=0 taps=0 tv=00", a_ov, a_taps, a_tv);
      end
      for (int i = 0; i < 20; i++) begin
         v = 8'(i + 1);
         step(1'b1, 1'b0, 4'd4, v);
         checks++;
         if (a_ov !== 1'b1) begin
            errors++;
            $display("FAIL basic_ov got=%b exp=1", a_ov);
         end
         e = (a_ov === 1'b1 && sb.size() > 0) ? sb.pop_front() : m_hold;
         checks++;
         if ({a_taps, a_tv, a_col} !== e) begin
            errors++;
            $display("FAIL basic n=%0d got taps=%h tv=%b col=%0d exp taps=%h tv=%b col=%0d", i, a_taps, a_tv, a_col, e.taps, e.tv, e.col);
         end
         if (i == 4) begin
            checks++;
            if (a_taps[7:0] !== 8'd1 || a_tv !== 2'b01) begin
               errors++;
               $display("FAIL basic_n4 got tap0=%0d tv=%b exp tap0=1 tv=01", a_taps[7:0], a_tv);
            end
         end
         if (i == 8) begin
            checks++;
            if (a_taps !== {8'd1, 8'd5} || a_tv !== 2'b11) begin
               errors++;
               $display("FAIL basic_n8 got taps=%h tv=%b exp taps=0105 tv=11", a_taps, a_tv);
            end
         end
      end
   endtask

   task automatic test_restart;
      exp_t e;
      step(1'b1, 1'b1, 4'd3, 8'hAA);
      checks++;
      if (a_ov !== 1'b1 || a_taps !== 16'h0 || a_tv !== 2'b00 || a_col !== 4'd0) begin
         errors++;
         $display("FAIL restart_first got ov=%b taps=%h tv=%b col=%0d exp ov=1 taps=0 tv=00 col=0", a_ov, a_taps, a_tv, a_col);
      end
      void'(sb.pop_front());
      for (int i = 1; i < 10; i++) begin
         step(1'b1, 1'b0, 4'd3, 8'(8'h40 + i));
         e = (a_ov === 1'b1 && sb.size() > 0) ? sb.pop_front() : m_hold;
         checks++;
         if ({a_taps, a_tv, a_col} !== e) begin
            errors++;
            $display("FAIL restart n=%0d got taps=%h tv=%b col=%0d exp taps=%h tv=%b col=%0d", i, a_taps, a_tv, a_col, e.taps, e.tv, e.col);
         end
         if (i == 3) begin
            checks++;
            if (a_taps[7:0] !== 8'hAA || a_tv !== 2'b01) begin
               errors++;
               $display("FAIL restart_n3 got tap0=%h tv=%b exp tap0=aa tv=01", a_taps[7:0], a_tv);
            end
         end
      end
   endtask

   task automatic test_gapped;
      exp_t e;
      logic ce;
      int   v;
      v = 1;
      step(1'b0, 1'b1, 4'd4, 8'd0);
      for (int i = 0; i < 40; i++) begin
         ce = (i % 4 == 0) || (i % 4 == 3);
         step(ce, 1'b0, 4'd4, 8'(v));
         if (ce) v++;
         checks++;
         if (a_ov !== ce) begin
            errors++;
            $display("FAIL gapped_ov i=%0d got=%b exp=%b", i, a_ov, ce);
         end
         e = (a_ov === 1'b1 && sb.size() > 0) ? sb.pop_front() : m_hold;
         checks++;
         if ({a_taps, a_tv, a_col} !== e) begin
            errors++;
            $display("FAIL gapped i=%0d got taps=%h tv=%b col=%0d exp taps=%h tv=%b col=%0d", i, a_taps, a_tv, a_col, e.taps, e.tv, e.col);
         end
      end
   endtask

   task automatic test_clamp;
      exp_t e;
      logic [LW-1:0] lens [2];
      lens[0] = 4'd0;
      lens[1] = 4'd12;
      for (int t = 0; t < 2; t++) begin
         step(1'b0, 1'b1, lens[t], 8'd0);
         for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 4'd0, 8'(i * 3 + 7 + t));
            e = (a_ov === 1'b1 && sb.size() > 0) ? sb.pop_front() : m_hold;
            checks++;
            if ({a_taps, a_tv, a_col} !== e) begin
               errors++;
               $display("FAIL clamp len=%0d n=%0d got taps=%h tv=%b col=%0d exp taps=%h tv=%b col=%0d", lens[t], i, a_taps, a_tv, a_col, e.taps, e.tv, e.col);
            end
            if (i == 8) begin
               checks++;
               if (a_taps[7:0] !== 8'(7 + t) || a_tv !== 2'b01) begin
                  errors++;
                  $display("FAIL clamp_n8 len=%0d got tap0=%0d tv=%b exp tap0=%0d tv=01", lens[t], a_taps[7:0], a_tv, 7 + t);
               end
            end
         end
      end
   endtask

   task automatic test_async_reset;
      exp_t e;
      step(1'b0, 1'b1, 4'd5, 8'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd5, 8'(i + 20));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({a_taps, a_tv, a_ov, a_col} !== '0) begin
         errors++;
         $display("FAIL async_reset got taps=%h tv=%b ov=%b col=%0d exp all zero", a_taps, a_tv, a_ov, a_col);
      end
      #1;
      rst = 1'b0;
      sb.delete(); hist.delete(); m_len = ML; m_hold = '0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 4'd0, 8'(i + 50));
         e = (a_ov === 1'b1 && sb.size() > 0) ? sb.pop_front() : m_hold;
         checks++;
         if ({a_taps, a_tv, a_col} !== e) begin
            errors++;
            $display("FAIL post_reset n=%0d got taps=%h tv=%b col=%0d exp taps=%h tv=%b col=%0d", i, a_taps, a_tv, a_col, e.taps, e.tv, e.col);
         end
      end
   endtask

   task automatic test_l1_four_taps;
      @(negedge clk);
      b_clr = 1'b1; b_ce = 1'b0; b_len = 4'd1;
      @(negedge clk);
      b_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b_ce = 1'b1; b_d = 8'(10 + i);
         @(negedge clk);
      end
      b_ce = 1'b0;
      checks++;
      if (b_taps !== {8'd10, 8'd11, 8'd12, 8'd13} || b_tv !== 4'b1111 || b_col !== 4'd0 || b_ov !== 1'b1) begin
         errors++;
         $display("FAIL l1_taps got taps=%h tv=%b col=%0d ov=%b exp taps=0a0b0c0d tv=1111 col=0 ov=1", b_taps, b_tv, b_col, b_ov);
      end
      @(negedge clk);
      checks++;
      if (b_ov !== 1'b0 || b_taps !== {8'd10, 8'd11, 8'd12, 8'd13}) begin
         errors++;
         $display("FAIL l1_hold got taps=%h ov=%b exp taps=0a0b0c0d ov=0", b_taps, b_ov);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_restart();
      test_gapped();
      test_clamp();
      test_async_reset();
      test_l1_four_taps();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/line_shift_taps_multi.md
Name: line_shift_taps_multi

Overview:
- Parametrised multi-line shift buffer for sliding-window image kernels (3x3, 5x5, ...).
- Holds NUM_TAPS delayed copies of the pixel stream, each exactly one line apart.
- Line length is selected at run time up to MAX_LINE, with per-tap fill tracking and frame-start clearing.
- Sits between pixel source and window/kernel logic; generalises the fixed two-tap, fixed-length line shifter.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- MAX_LINE, 640, maximum line length (words per tap memory).
- NUM_TAPS, 2, number of line-delayed outputs (>=1).
- LEN_W, 11, width of line_len / col_idx; must satisfy 2^LEN_W > MAX_LINE.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  sample-accept strobe; all state frozen when low (except sync_clr).
- sync_clr  in  1  frame/stream restart; latches line_len, clears fill and pointer.
- line_len  in  LEN_W  requested line length; sampled only on sync_clr.
- shiftin  in  DATA_WIDTH  incoming pixel.
- taps  out  NUM_TAPS*DATA_WIDTH  tap k in bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 is one line old.
- taps_valid  out  NUM_TAPS  bit k high once tap k carries real data.
- out_valid  out  1  high the cycle after an accepted sample (taps updated).
- col_idx  out  LEN_W  column of the most recently accepted sample, 0..L-1.

Behaviour:
- Reset: ptr=0, fill=0, L=MAX_LINE, taps=0, taps_valid=0, out_valid=0, col_idx=0. Memory contents are not cleared.
- Active length L:
  - latched from line_len on sync_clr;
  - line_len=0 or line_len>MAX_LINE forces L=MAX_LINE.
- Storage:
  - NUM_TAPS memories of MAX_LINE words, sharing a single pointer ptr (0..L-1).
- Accepted sample (clken=1), at the clock edge:
  - r_k = mem_k[ptr] (pre-write value);
  - mem_0[ptr] <= shiftin;
  - mem_k[ptr] <= r_{k-1} for k>=1;
  - taps[k] <= r_k;
  - col_idx <= ptr;
  - ptr <= (ptr==L-1) ? 0 : ptr+1;
  - fill <= min(fill+1, NUM_TAPS*L).
- Required relation: for the n-th accepted sample after sync_clr/reset (n from 0), taps[k] = s(n-(k+1)*L) registered at that edge.
- Validity gating:
  - taps_valid[k] = 1 iff n >= (k+1)*L, i.e. prior fill >= (k+1)*L;
  - taps[k] must read 0 whenever taps_valid[k]=0, so stale memory never leaks.
- Latency: one clock from the accepting edge to taps/out_valid update. out_valid is a registered copy of clken.
- clken=0: ptr, fill, taps, taps_valid and col_idx hold; out_valid=0 next cycle.
- sync_clr=1 with clken=0:
  - ptr<=0, fill<=0, taps_valid<=0, taps<=0, L latched;
  - out_valid=0.
- sync_clr=1 with clken=1 in the same cycle:
  - clear takes priority, then the sample is accepted as sample n=0 at ptr=0 with the new L;
  - after the edge: ptr=1 (or 0 if L=1), fill=1, taps all 0, taps_valid=0, out_valid=1, col_idx=0.
- Wrap: ptr returns to 0 after L-1. col_idx follows the same sequence.
- Saturation: fill saturates at NUM_TAPS*L; once saturated, all taps_valid stay high until sync_clr/reset.
- L=1 edge case: tap k equals the input delayed k+1 accepted samples.
- Reset mid-line: asynchronous; all outputs go to their reset values immediately.

Test Plan:
- NUM_TAPS=2, MAX_LINE=8.
  - Action: sync_clr with line_len=4, then feed 1,2,3,... on every cycle.
  - Expected at sample n=4 (value 5): taps[0]=1, taps_valid=01. At n=8 (value 9): taps[0]=5, taps[1]=1, taps_valid=11. col_idx cycles 0,1,2,3.
- Gapped clken:
  - Action: same stream with clken pattern 1,0,0,1 repeating.
  - Expected: identical tap sequence per accepted sample; out_valid high only after accepting edges; outputs hold during gaps.
- Clamp:
  - Action: line_len=0, and separately line_len=12 with MAX_LINE=8.
  - Expected: both behave as L=8; taps[0] first valid at n=8 with value s(0).
- Mid-stream restart:
  - Action: after saturation, assert sync_clr together with clken and shiftin=0xAA, line_len=3.
  - Expected: taps=0, taps_valid=00, col_idx=0; taps[0]=0xAA at n=3; no pre-restart data ever appears on taps.
- Asynchronous reset:
  - Action: assert reset between clock edges mid-line.
  - Expected: taps, taps_valid, out_valid and col_idx go to 0 before the next edge; L=MAX_LINE afterward.
- NUM_TAPS=4, L=1:
  - Action: feed 10,11,12,13,14.
  - Expected: at value 14, taps = {10,11,12,13} for taps[3..0]; taps_valid=1111.
